// File: rtl/pwm_regs.sv
// pwm_regs: MMIO register bank assembling 16-bit PWM settings from byte writes.
// Define PWM_REGS_SHADOW_EN to double-buffer DIV/PERIOD/DUTY until a period boundary.
module pwm_regs #(
    parameter logic [15:0] BASE_ADDR = 16'hF010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mmio_addr,
    input  logic [7:0]  mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [7:0]  mmio_rdata,
    input  logic        period_wrap,
    output logic [15:0] pwm_ctrl,
    output logic [15:0] pwm_div,
    output logic [15:0] pwm_period,
    output logic [15:0] pwm_duty,
    output logic        pending
);
    logic [15:0] off;
    logic        in_win, wr, ctrl_wr, lo_wr, hi_wr, stat;
    logic [1:0]  idx;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [7:0]  lo_hold_q, lo_hold_d, rdata_q, rdata_d, rbyte;
    logic [15:0] act_q [3];
    logic [15:0] act_d [3];
    logic [15:0] view [3];
    logic [15:0] word;

    assign off     = mmio_addr - BASE_ADDR;
    assign in_win  = off < 16'd9;
    assign wr      = mmio_we && in_win;
    assign idx     = off[2:1] - 2'd1;
    assign ctrl_wr = wr && off[3:0] == 4'd0;
    assign lo_wr   = wr && !off[3] && off[2:1] != 2'd0 && !off[0];
    assign hi_wr   = wr && !off[3] && off[2:1] != 2'd0 && off[0];

`ifdef PWM_REGS_SHADOW_EN
    logic [15:0] stg_q [3];
    logic [15:0] stg_d [3];
    logic        pending_q, pending_d, xfer;

    // A HI write on a transfer edge is staged behind the values being committed
    always_comb begin
        xfer      = pending_q && (period_wrap || !ctrl_q[0] || (wr && off[3] && mmio_wdata[0]));
        pending_d = hi_wr || (pending_q && !xfer);
        stat      = pending_q;
        for (int i = 0; i < 3; i++) begin
            stg_d[i] = (hi_wr && idx == 2'(i)) ? {mmio_wdata, lo_hold_q} : stg_q[i];
            act_d[i] = xfer ? stg_q[i] : act_q[i];
            view[i]  = stg_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_q     <= '{16'd1, 16'd0, 16'd0};
            pending_q <= 1'b0;
        end else begin
            stg_q     <= stg_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    logic unused_wrap;
    assign unused_wrap = period_wrap;

    always_comb begin
        stat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            act_d[i] = (hi_wr && idx == 2'(i)) ? {mmio_wdata, lo_hold_q} : act_q[i];
            view[i]  = act_q[i];
        end
    end

    assign pending = 1'b0;
`endif

    always_comb begin
        ctrl_d    = ctrl_wr ? mmio_wdata[1:0] : ctrl_q;
        lo_hold_d = lo_wr ? mmio_wdata : lo_hold_q;
        word      = off[3] ? {15'd0, stat} :
                    off[2:1] == 2'd0 ? {14'd0, ctrl_q} :
                    idx == 2'd0 ? view[0] :
                    idx == 2'd1 ? view[1] : view[2];
        rbyte     = off[0] ? word[15:8] : word[7:0];
        rdata_d   = mmio_re ? (in_win ? rbyte : 8'd0) : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= 2'd0;
            lo_hold_q <= 8'd0;
            rdata_q   <= 8'd0;
            act_q     <= '{16'd1, 16'd0, 16'd0};
        end else begin
            ctrl_q    <= ctrl_d;
            lo_hold_q <= lo_hold_d;
            rdata_q   <= rdata_d;
            act_q     <= act_d;
        end
    end

    assign mmio_rdata = rdata_q;
    assign pwm_ctrl   = {14'd0, ctrl_q};
    assign pwm_div    = act_q[0];
    assign pwm_period = act_q[1];
    assign pwm_duty   = act_q[2];
endmodule

// File: tb/tb_pwm_regs.sv
// tb_pwm_regs: directed checks of pwm_regs in either build (shadowed or direct).
module tb_pwm_regs;
    logic        clk = 1'b0, reset = 1'b1;
    logic [15:0] mmio_addr = 16'd0;
    logic [7:0]  mmio_wdata = 8'd0;
    logic        mmio_we = 1'b0, mmio_re = 1'b0, period_wrap = 1'b0;
    logic [7:0]  mmio_rdata;
    logic [15:0] pwm_ctrl, pwm_div, pwm_period, pwm_duty;
    logic        pending;
    logic [7:0]  r;
    int          total = 0, bad = 0;
    localparam logic [15:0] B = 16'hF010;
`ifdef PWM_REGS_SHADOW_EN
    localparam logic SH = 1'b1;
`else
    localparam logic SH = 1'b0;
`endif

    pwm_regs dut (
        .clk(clk), .reset(reset), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_we(mmio_we), .mmio_re(mmio_re), .mmio_rdata(mmio_rdata),
        .period_wrap(period_wrap), .pwm_ctrl(pwm_ctrl), .pwm_div(pwm_div),
        .pwm_period(pwm_period), .pwm_duty(pwm_duty), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic w = 1'b0);
        @(negedge clk);
        mmio_addr = a; mmio_wdata = d; mmio_we = 1'b1; period_wrap = w;
        @(negedge clk);
        mmio_we = 1'b0; period_wrap = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        mmio_addr = a; mmio_re = 1'b1;
        @(negedge clk);
        mmio_re = 1'b0; d = mmio_rdata;
    endtask

    initial begin
        logic [7:0] rst_exp [9];
        rst_exp = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ctrl", pwm_ctrl, 16'h0000);
        check("rst_div", pwm_div, 16'h0001);
        check("rst_period", pwm_period, 16'h0000);
        check("rst_duty", pwm_duty, 16'h0000);
        check("rst_pending", 16'(pending), 16'h0000);
        check("rst_rdata", 16'(mmio_rdata), 16'h0000);
        for (int i = 0; i < 9; i++) begin
            rd(B + 16'(i), r);
            check($sformatf("rst_rd%0d", i), 16'(r), 16'(rst_exp[i]));
        end

        wr(B + 16'd0, 8'h01);
        check("ctrl_en", pwm_ctrl, 16'h0001);
        wr(B + 16'd1, 8'hFF);
        check("ctrl_hi_ign", pwm_ctrl, 16'h0001);
        rd(B + 16'd1, r);
        check("ctrl_hi_rd", 16'(r), 16'h0000);

        wr(B + 16'd4, 8'h0F);
        check("per_lo_only", pwm_period, 16'h0000);
        wr(B + 16'd5, 8'h27);
        repeat (20) @(negedge clk);
        check("per_hold", pwm_period, SH ? 16'h0000 : 16'h270F);
        check("per_pending", 16'(pending), 16'(SH));
        @(negedge clk) period_wrap = 1'b1;
        @(negedge clk) period_wrap = 1'b0;
        check("per_wrap", pwm_period, 16'h270F);
        check("per_wrap_pend", 16'(pending), 16'h0000);
        rd(B + 16'd4, r);
        check("per_rd_lo", 16'(r), 16'h000F);
        rd(B + 16'd5, r);
        check("per_rd_hi", 16'(r), 16'h0027);

        wr(B + 16'd0, 8'h00);
        wr(B + 16'd6, 8'hE8);
        wr(B + 16'd7, 8'h03);
        check("duty_hi_edge", pwm_duty, SH ? 16'h0000 : 16'h03E8);
        @(negedge clk);
        check("duty_dis", pwm_duty, 16'h03E8);
        check("duty_pend", 16'(pending), 16'h0000);

        wr(B + 16'd0, 8'h01);
        wr(B + 16'd2, 8'h05);
        wr(B + 16'd3, 8'h00);
        check("div_staged", pwm_div, SH ? 16'h0001 : 16'h0005);
        check("div_pend", 16'(pending), 16'(SH));
        wr(B + 16'd2, 8'h07);
        wr(B + 16'd3, 8'h00, 1'b1);
        check("div_coinc", pwm_div, SH ? 16'h0005 : 16'h0007);
        check("div_coinc_pend", 16'(pending), 16'(SH));
        rd(B + 16'd2, r);
        check("div_rd_staged", 16'(r), 16'h0007);
        rd(B + 16'd8, r);
        check("stat_rd_pend", 16'(r), 16'(SH));
        wr(B + 16'd8, 8'h01);
        check("force_div", pwm_div, 16'h0007);
        check("force_pend", 16'(pending), 16'h0000);
        rd(B + 16'd8, r);
        check("stat_rd_clr", 16'(r), 16'h0000);

        wr(B + 16'd7, 8'h12);
        wr(B + 16'd8, 8'hFF);
        check("duty_no_lo", pwm_duty, 16'h1207);

        @(negedge clk);
        mmio_addr = B + 16'd5; mmio_wdata = 8'h55; mmio_we = 1'b1; mmio_re = 1'b1;
        @(negedge clk);
        mmio_we = 1'b0; mmio_re = 1'b0;
        check("rw_same", 16'(mmio_rdata), 16'h0027);
        wr(B + 16'd8, 8'h01);
        check("rw_period", pwm_period, 16'h5507);

        wr(B + 16'd2, 8'h00);
        wr(B + 16'd3, 8'h00);
        wr(B + 16'd8, 8'h01);
        check("div_zero", pwm_div, 16'h0000);

        wr(16'hF020, 8'h00);
        wr(16'hF00F, 8'h00);
        check("oow_ctrl", pwm_ctrl, 16'h0001);
        check("oow_pend", 16'(pending), 16'h0000);
        rd(16'hF020, r);
        check("oow_rd", 16'(r), 16'h0000);
        rd(B + 16'd0, r);
        check("ctrl_rd", 16'(r), 16'h0001);

        wr(B + 16'd2, 8'h99);
        wr(B + 16'd3, 8'h00);
        check("pre_rst_pend", 16'(pending), 16'(SH));
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst2_div", pwm_div, 16'h0001);
        check("rst2_ctrl", pwm_ctrl, 16'h0000);
        check("rst2_pend", 16'(pending), 16'h0000);
        rd(B + 16'd2, r);
        check("rst2_rd_div", 16'(r), 16'h0001);
        wr(B + 16'd7, 8'h00);
        @(negedge clk);
        check("rst2_lo_hold", pwm_duty, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
